// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 multicycle control unit: opcodes, ALU function
// codes, control-word field positions and the sequencer state type.
package legv8_pkg;

  // R-type and D-type opcodes occupy instruction bits [31:21]
  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpEor  = 11'b11001010000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  // ADDI [31:22], CBZ [31:24], B [31:26]
  localparam logic [9:0]  OpAddi = 10'b1001000100;
  localparam logic [7:0]  OpCbz  = 8'b10110100;
  localparam logic [5:0]  OpB    = 6'b000101;

  localparam logic [4:0] FsAnd = 5'b00000;
  localparam logic [4:0] FsOrr = 5'b00001;
  localparam logic [4:0] FsAdd = 5'b00010;
  localparam logic [4:0] FsEor = 5'b00011;
  localparam logic [4:0] FsSub = 5'b01010;

  localparam int unsigned CwWidth    = 35;
  localparam int unsigned CwBSel     = 25;
  localparam int unsigned CwSaLsb    = 20;
  localparam int unsigned CwSbLsb    = 15;
  localparam int unsigned CwDaLsb    = 10;
  localparam int unsigned CwRegWrite = 9;
  localparam int unsigned CwMemWrite = 8;
  localparam int unsigned CwFsLsb    = 3;
  localparam int unsigned CwC0       = 2;
  localparam int unsigned CwEnMem    = 1;
  localparam int unsigned CwEnAlu    = 0;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StMem1,
    StMem2,
    StHalt
  } state_e;

  typedef struct packed {
    logic       bsel;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] da;
    logic       reg_write;
    logic       mem_write;
    logic [4:0] fs;
    logic       c0;
    logic       en_mem;
    logic       en_alu;
  } ctrl_t;

  // Place decoded fields into the datapath control-word layout; reserved bits stay 0
  function automatic logic [CwWidth-1:0] pack_cw(input ctrl_t c);
    logic [CwWidth-1:0] w;
    w = '0;
    w[CwBSel]         = c.bsel;
    w[CwSaLsb +: 5]   = c.sa;
    w[CwSbLsb +: 5]   = c.sb;
    w[CwDaLsb +: 5]   = c.da;
    w[CwRegWrite]     = c.reg_write;
    w[CwMemWrite]     = c.mem_write;
    w[CwFsLsb +: 5]   = c.fs;
    w[CwC0]           = c.c0;
    w[CwEnMem]        = c.en_mem;
    w[CwEnAlu]        = c.en_alu;
    return w;
  endfunction

endpackage

// File: rtl/legv8_decoder.sv
// Combinational instruction decoder: IR -> control word, constant, branch info.
module legv8_decoder
  import legv8_pkg::*;
(
  input  logic [31:0] ir,
  output logic [34:0] cw,
  output logic [63:0] constant,
  output logic [63:0] br_offset,
  output logic        br_uncond,
  output logic        br_cbz,
  output logic        is_load,
  output logic        illegal
);

  ctrl_t       c;
  logic [10:0] op11;

  assign op11 = ir[31:21];

  // Decode the supported subset; anything else is flagged illegal with all strobes off
  always_comb begin
    c         = '0;
    constant  = '0;
    br_offset = '0;
    br_uncond = 1'b0;
    br_cbz    = 1'b0;
    is_load   = 1'b0;
    illegal   = 1'b0;
    case (op11)
      OpAdd, OpSub, OpAnd, OpOrr, OpEor: begin
        c.sa        = ir[9:5];
        c.sb        = ir[20:16];
        c.da        = ir[4:0];
        c.reg_write = 1'b1;
        c.en_alu    = 1'b1;
        case (op11)
          OpSub: begin
            c.fs = FsSub;
            c.c0 = 1'b1;
          end
          OpAnd:   c.fs = FsAnd;
          OpOrr:   c.fs = FsOrr;
          OpEor:   c.fs = FsEor;
          default: c.fs = FsAdd;
        endcase
      end
      OpLdur: begin
        c.sa     = ir[9:5];
        c.da     = ir[4:0];
        c.bsel   = 1'b1;
        c.fs     = FsAdd;
        c.en_mem = 1'b1;
        constant = {{55{ir[20]}}, ir[20:12]};
        is_load  = 1'b1;
      end
      OpStur: begin
        c.sa        = ir[9:5];
        c.sb        = ir[4:0];
        c.bsel      = 1'b1;
        c.fs        = FsAdd;
        c.mem_write = 1'b1;
        constant    = {{55{ir[20]}}, ir[20:12]};
      end
      default: begin
        if (ir[31:22] == OpAddi) begin
          c.sa        = ir[9:5];
          c.da        = ir[4:0];
          c.bsel      = 1'b1;
          c.fs        = FsAdd;
          c.reg_write = 1'b1;
          c.en_alu    = 1'b1;
          constant    = {52'd0, ir[21:10]};
        end else if (ir[31:24] == OpCbz) begin
          c.sa      = 5'd31;
          c.sb      = ir[4:0];
          c.fs      = FsAdd;
          br_cbz    = 1'b1;
          br_offset = {{43{ir[23]}}, ir[23:5], 2'b00};
        end else if (ir[31:26] == OpB) begin
          br_uncond = 1'b1;
          br_offset = {{36{ir[25]}}, ir[25:0], 2'b00};
        end else begin
          illegal = 1'b1;
        end
      end
    endcase
  end

  assign cw = pack_cw(c);

endmodule

// File: rtl/control_unit_legv8.sv
// LEGv8 multicycle control unit: fetch via req/ack, decode, PC sequencing.
module control_unit_legv8
  import legv8_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  status,
  input  logic [31:0] imem_data,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  output logic [34:0] ControlWord,
  output logic [63:0] constant,
  output logic        halted
);

  state_e      state_q;
  logic [63:0] pc_q;
  logic [31:0] ir_q;
  logic [63:0] pc_next;

  logic [34:0] dec_cw;
  logic [63:0] dec_const;
  logic [63:0] br_offset;
  logic        br_uncond;
  logic        br_cbz;
  logic        is_load;
  logic        illegal;

  // Only the Z flag steers sequencing
  logic unused_status;
  assign unused_status = ^status[3:1];

  legv8_decoder u_decoder (
    .ir        (ir_q),
    .cw        (dec_cw),
    .constant  (dec_const),
    .br_offset (br_offset),
    .br_uncond (br_uncond),
    .br_cbz    (br_cbz),
    .is_load   (is_load),
    .illegal   (illegal)
  );

  // PC at EXEC exit: branch target when taken, else fall through
  always_comb begin
    pc_next = pc_q + 64'd4;
    if (br_uncond || (br_cbz && status[0])) begin
      pc_next = pc_q + br_offset;
    end
  end

  // Sequencer: state, PC and instruction register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      case (state_q)
        StIdle:  state_q <= StFetch;
        StFetch: begin
          if (imem_ack) begin
            ir_q    <= imem_data;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (illegal) begin
            state_q <= StHalt;
          end else if (is_load) begin
            state_q <= StMem1;
          end else begin
            pc_q    <= pc_next;
            state_q <= StFetch;
          end
        end
        StMem1:  state_q <= StMem2;
        StMem2: begin
          pc_q    <= pc_q + 64'd4;
          state_q <= StFetch;
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs: control word only live in execute states; load writes back in MEM2
  always_comb begin
    imem_req    = (state_q == StFetch);
    halted      = (state_q == StHalt);
    imem_addr   = pc_q;
    ControlWord = '0;
    constant    = '0;
    if (state_q == StExec || state_q == StMem1 || state_q == StMem2) begin
      ControlWord = dec_cw;
      constant    = dec_const;
      if (state_q == StMem2) begin
        ControlWord[CwRegWrite] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_control_unit_legv8.sv
// Self-checking bench for control_unit_legv8: a small program run from a vector table,
// plus stall, halt and mid-load reset sequences.
module tb_control_unit_legv8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  status;
  logic [31:0] imem_data;
  logic        imem_ack;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [34:0] ControlWord;
  logic [63:0] constant;
  logic        halted;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  control_unit_legv8 dut (
    .clock       (clock),
    .reset       (reset),
    .status      (status),
    .imem_data   (imem_data),
    .imem_ack    (imem_ack),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .ControlWord (ControlWord),
    .constant    (constant),
    .halted      (halted)
  );

  typedef struct {
    logic [31:0] word;
    logic [63:0] pc;
    logic [3:0]  st;
    int          delay;
    logic [34:0] cw;
    logic [63:0] k;
    logic        load;
    string       name;
  } vec_t;

  typedef struct {
    logic [34:0] cw;
    logic [63:0] k;
    string       name;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  function automatic logic [34:0] mk(input logic bsel, input logic [4:0] sa,
                                     input logic [4:0] sbf, input logic [4:0] da,
                                     input logic rw, input logic mw, input logic [4:0] fs,
                                     input logic c0, input logic enm, input logic ena);
    return {9'd0, bsel, sa, sbf, da, rw, mw, fs, c0, enm, ena};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for a fetch request, sampling on falling edges
  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) return;
      @(negedge clock);
    end
  endtask

  // Serve one fetch after 'delay' stalled cycles; returns at the EXEC falling edge
  task automatic fetch(input logic [31:0] word, input int delay, input logic [63:0] pc,
                       input string nm);
    for (int d = 0; d < delay; d++) begin
      imem_ack  = 1'b0;
      imem_data = 32'hFFFF_FFFF;
      @(negedge clock);
      chk({nm, " stall req"}, {63'd0, imem_req}, 64'd1);
      chk({nm, " stall addr"}, imem_addr, pc);
      chk({nm, " stall cw"}, {29'd0, ControlWord}, 64'd0);
    end
    imem_ack  = 1'b1;
    imem_data = word;
    @(negedge clock);
    imem_ack  = 1'b0;
    imem_data = 32'hFFFF_FFFF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    exp_t        e;
    logic [34:0] m2;
    logic [34:0] ldur_cw;

    vecs[0]  = '{32'h8B020023, 64'h00, 4'h1, 0, mk(0,  1,  2,  3, 1, 0, 5'd2,  0, 0, 1),
                 64'h0, 1'b0, "add"};
    vecs[1]  = '{32'hCB0600A4, 64'h04, 4'h0, 1, mk(0,  5,  6,  4, 1, 0, 5'd10, 1, 0, 1),
                 64'h0, 1'b0, "sub"};
    vecs[2]  = '{32'h91048D49, 64'h08, 4'h1, 5, mk(1, 10,  0,  9, 1, 0, 5'd2,  0, 0, 1),
                 64'h123, 1'b0, "addi"};
    vecs[3]  = '{32'h14000001, 64'h0C, 4'h0, 0, 35'd0, 64'h0, 1'b0, "b"};
    vecs[4]  = '{32'hB4000065, 64'h10, 4'h1, 0, mk(0, 31,  5,  0, 0, 0, 5'd2,  0, 0, 0),
                 64'h0, 1'b0, "cbz taken"};
    vecs[5]  = '{32'hF81F8068, 64'h1C, 4'h1, 2, mk(1,  3,  8,  0, 0, 1, 5'd2,  0, 0, 0),
                 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, "stur"};
    vecs[6]  = '{32'hB4FFFF80, 64'h20, 4'h1, 0, mk(0, 31,  0,  0, 0, 0, 5'd2,  0, 0, 0),
                 64'h0, 1'b0, "cbz back taken"};
    vecs[7]  = '{32'hB4000065, 64'h10, 4'h0, 0, mk(0, 31,  5,  0, 0, 0, 5'd2,  0, 0, 0),
                 64'h0, 1'b0, "cbz not taken"};
    vecs[8]  = '{32'hAA0D018B, 64'h14, 4'h0, 1, mk(0, 12, 13, 11, 1, 0, 5'd1,  0, 0, 1),
                 64'h0, 1'b0, "orr"};
    vecs[9]  = '{32'hF8408047, 64'h18, 4'h1, 0, mk(1,  2,  0,  7, 0, 0, 5'd2,  0, 1, 0),
                 64'h8, 1'b1, "ldur"};
    vecs[10] = '{32'hF81F8068, 64'h1C, 4'h0, 0, mk(1,  3,  8,  0, 0, 1, 5'd2,  0, 0, 0),
                 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, "stur2"};
    vecs[11] = '{32'hB4FFFF80, 64'h20, 4'h0, 0, mk(0, 31,  0,  0, 0, 0, 5'd2,  0, 0, 0),
                 64'h0, 1'b0, "cbz back not taken"};
    vecs[12] = '{32'hCA040062, 64'h24, 4'h1, 0, mk(0,  3,  4,  2, 1, 0, 5'd3,  0, 0, 1),
                 64'h0, 1'b0, "eor"};
    vecs[13] = '{32'h00000000, 64'h28, 4'h1, 0, 35'd0, 64'h0, 1'b0, "illegal"};
    ldur_cw  = vecs[9].cw;

    status    = 4'h0;
    imem_ack  = 1'b0;
    imem_data = 32'hFFFF_FFFF;

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset cw", {29'd0, ControlWord}, 64'd0);
    chk("reset const", constant, 64'd0);
    chk("reset req", {63'd0, imem_req}, 64'd0);
    chk("reset halted", {63'd0, halted}, 64'd0);
    chk("reset addr", imem_addr, 64'd0);
    reset = 1'b1;
    chk("idle req", {63'd0, imem_req}, 64'd0);
    @(negedge clock);
    chk("first fetch req", {63'd0, imem_req}, 64'd1);

    // Program run: addresses chain through branches; expectations queued per fetch
    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      wait_req();
      chk({v.name, " req"}, {63'd0, imem_req}, 64'd1);
      chk({v.name, " fetch addr"}, imem_addr, v.pc);
      status = v.st;
      sb.push_back('{v.cw, v.k, {v.name, " exec"}});
      if (v.load) begin
        sb.push_back('{v.cw, v.k, {v.name, " mem1"}});
        m2    = v.cw;
        m2[9] = 1'b1;
        sb.push_back('{m2, v.k, {v.name, " mem2"}});
      end
      fetch(v.word, v.delay, v.pc, v.name);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, " cw"}, {29'd0, ControlWord}, {29'd0, e.cw});
        chk({e.name, " const"}, constant, e.k);
        chk({e.name, " req low"}, {63'd0, imem_req}, 64'd0);
        if (sb.size() > 0) @(negedge clock);
      end
    end

    // Halt persists
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("halt halted", {63'd0, halted}, 64'd1);
      chk("halt req", {63'd0, imem_req}, 64'd0);
      chk("halt cw", {29'd0, ControlWord}, 64'd0);
      chk("halt addr", imem_addr, 64'h28);
    end

    // Reset recovers from halt
    reset = 1'b0;
    #1;
    chk("recover halted", {63'd0, halted}, 64'd0);
    chk("recover addr", imem_addr, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("recover req", {63'd0, imem_req}, 64'd1);
    chk("recover fetch addr", imem_addr, 64'd0);

    // Reset asserted during MEM1 of a load
    status = 4'h0;
    fetch(32'hF8408047, 0, 64'd0, "ldur rst");
    chk("ldur rst exec cw", {29'd0, ControlWord}, {29'd0, ldur_cw});
    @(negedge clock);
    chk("ldur rst mem1 cw", {29'd0, ControlWord}, {29'd0, ldur_cw});
    chk("ldur rst mem1 const", constant, 64'd8);
    #2;
    reset = 1'b0;
    #1;
    chk("mid reset cw", {29'd0, ControlWord}, 64'd0);
    chk("mid reset const", constant, 64'd0);
    chk("mid reset req", {63'd0, imem_req}, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("restart req", {63'd0, imem_req}, 64'd1);
    chk("restart addr", imem_addr, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
